// File: rtl/ahbl_copy_pkg.sv
// Shared constants for the AHB-Lite block-copy master: bus encodings, FSM state codes, address helper.
package ahbl_copy_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_READ  = 2'b01;
    localparam state_t ST_WRITE = 2'b10;
    localparam state_t ST_LAST  = 2'b11;

    // Byte addresses are word aligned by clearing the two low bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ahbl_copy_addr_gen.sv
// Source/destination address and remaining-word counters for the copy master.
module ahbl_copy_addr_gen
    import ahbl_copy_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             load,
    input  logic             step,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic [31:0]      src_cur,
    output logic [31:0]      dst_cur,
    output logic [31:0]      src_next,
    output logic             more
);

    logic [31:0]      src_r;
    logic [31:0]      dst_r;
    logic [LEN_W-1:0] rem_r;

    // Latch the job on acceptance, advance one word per completed write address phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            src_r <= 32'h0000_0000;
            dst_r <= 32'h0000_0000;
            rem_r <= {LEN_W{1'b0}};
        end else if (load) begin
            src_r <= word_align(src_addr);
            dst_r <= word_align(dst_addr);
            rem_r <= len_words;
        end else if (step) begin
            src_r <= src_r + 32'd4;
            dst_r <= dst_r + 32'd4;
            rem_r <= rem_r - LEN_W'(1);
        end else begin
            src_r <= src_r;
            dst_r <= dst_r;
            rem_r <= rem_r;
        end
    end

    assign src_cur  = src_r;
    assign dst_cur  = dst_r;
    assign src_next = src_r + 32'd4;
    assign more     = (rem_r > LEN_W'(1));

endmodule

// File: rtl/ahbl_copy_master.sv
// AHB-Lite block-copy master: pipelined read/write, two bus cycles per word at zero wait states.
// Optional irq/irq_clr ports when AHBL_COPY_IRQ_EN is defined.
module ahbl_copy_master
    import ahbl_copy_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic [2:0]       HSIZE,
    output logic             HWRITE,
    output logic [31:0]      HWDATA,
`ifdef AHBL_COPY_IRQ_EN
    output logic             irq,
    input  logic             irq_clr,
`endif
    input  logic             HREADY,
    input  logic [31:0]      HRDATA
);

    state_t      state_r;
    logic [31:0] haddr_r;
    logic [1:0]  htrans_r;
    logic [2:0]  hsize_r;
    logic        hwrite_r;
    logic [31:0] hwdata_r;
    logic        busy_r;
    logic        done_r;

    logic        load_s;
    logic        step_s;
    logic        done_set_s;
    logic [31:0] src_cur_s;
    logic [31:0] dst_cur_s;
    logic [31:0] src_next_s;
    logic        more_s;

    ahbl_copy_addr_gen #(.LEN_W(LEN_W)) u_addr_gen (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .load      (load_s),
        .step      (step_s),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .src_cur   (src_cur_s),
        .dst_cur   (dst_cur_s),
        .src_next  (src_next_s),
        .more      (more_s)
    );

    // Job acceptance, address stepping and completion strobes.
    always_comb begin
        load_s     = 1'b0;
        step_s     = 1'b0;
        done_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s     = (len_words != {LEN_W{1'b0}});
                    done_set_s = (len_words == {LEN_W{1'b0}});
                end else begin
                    load_s     = 1'b0;
                    done_set_s = 1'b0;
                end
            end
            ST_WRITE: step_s     = HREADY;
            ST_LAST:  done_set_s = HREADY;
            default:  step_s     = 1'b0;
        endcase
    end

    // Copy FSM and registered AHB outputs; a low HREADY freezes everything outside IDLE.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r  <= ST_IDLE;
            haddr_r  <= 32'h0000_0000;
            htrans_r <= HTRANS_IDLE;
            hsize_r  <= HSIZE_WORD;
            hwrite_r <= 1'b0;
            hwdata_r <= 32'h0000_0000;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r  <= done_set_s;
            hsize_r <= HSIZE_WORD;
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        haddr_r  <= word_align(src_addr);
                        hwrite_r <= 1'b0;
                        htrans_r <= HTRANS_NONSEQ;
                        busy_r   <= 1'b1;
                        state_r  <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (HREADY) begin
                        haddr_r  <= dst_cur_s;
                        hwrite_r <= 1'b1;
                        htrans_r <= HTRANS_NONSEQ;
                        state_r  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Read data arrives during the write address phase and becomes the next write data.
                    if (HREADY) begin
                        hwdata_r <= HRDATA;
                        hwrite_r <= 1'b0;
                        if (more_s) begin
                            haddr_r  <= src_next_s;
                            htrans_r <= HTRANS_NONSEQ;
                            state_r  <= ST_READ;
                        end else begin
                            htrans_r <= HTRANS_IDLE;
                            state_r  <= ST_LAST;
                        end
                    end
                end
                ST_LAST: begin
                    if (HREADY) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    htrans_r <= HTRANS_IDLE;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

`ifdef AHBL_COPY_IRQ_EN
    logic irq_r;

    // Sticky completion interrupt; a coincident set beats the clear.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            irq_r <= 1'b0;
        end else if (done_set_s) begin
            irq_r <= 1'b1;
        end else if (irq_clr) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    assign irq = irq_r;
`endif

    assign busy   = busy_r;
    assign done   = done_r;
    assign HADDR  = haddr_r;
    assign HTRANS = htrans_r;
    assign HSIZE  = hsize_r;
    assign HWRITE = hwrite_r;
    assign HWDATA = hwdata_r;

endmodule

// File: tb/tb_ahbl_copy_master.sv
// Directed bench for ahbl_copy_master with a small wrap-decoding AHB-Lite memory slave.
module tb_ahbl_copy_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        busy;
    logic        done;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
`ifdef AHBL_COPY_IRQ_EN
    logic        irq;
    logic        irq_clr;
`endif

    always #5 HCLK = ~HCLK;

    ahbl_copy_master #(.LEN_W(16)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
`ifdef AHBL_COPY_IRQ_EN
        .irq       (irq),
        .irq_clr   (irq_clr),
`endif
        .HREADY    (HREADY),
        .HRDATA    (HRDATA)
    );

    // Memory slave: word index is HADDR[9:2], so 0xFFFFFFFC and 0x00000000 are adjacent words.
    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'h00;
    logic [31:0] pre_data = 32'h0;
    logic        dp_valid;
    logic        dp_write;
    logic [7:0]  dp_idx;
    logic [32:0] log_q [$];

    always @(posedge HCLK) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        if (HRESET) begin
            dp_valid <= 1'b0;
        end else if (HREADY) begin
            if (dp_valid && dp_write) mem[dp_idx] <= HWDATA;
            dp_valid <= (HTRANS == 2'b10);
            dp_write <= HWRITE;
            dp_idx   <= HADDR[9:2];
            if (HTRANS == 2'b10) log_q.push_back({HWRITE, HADDR});
        end
    end

    assign HRDATA = (dp_valid && !dp_write) ? mem[dp_idx] : 32'h0;

    int checks = 0;
    int failures = 0;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pre_idx  = idx;
        pre_data = data;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    // Start a copy and wait for done; optional wait-state pattern 1,1,1,0,0 repeating.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input logic stall, output int edges, output int stalls);
        logic [4:0]  pat;
        logic [67:0] prev;
        int          k;
        pat = 5'b00111;
        src_addr = s;
        dst_addr = d;
        len_words = n;
        HREADY = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", {67'd0, busy}, 68'd1);
        edges = 0;
        stalls = 0;
        k = 0;
        while (!done && edges < 400) begin
            prev = {HADDR, HTRANS, HWRITE, HWDATA, busy};
            HREADY = stall ? pat[k % 5] : 1'b1;
            k++;
            tick();
            edges++;
            if (!HREADY) begin
                stalls++;
                chk("stable_while_wait", {HADDR, HTRANS, HWRITE, HWDATA, busy}, prev);
            end
        end
        HREADY = 1'b1;
        chk("done_seen", {67'd0, done}, 68'd1);
        chk("busy_clear_at_done", {67'd0, busy}, 68'd0);
    endtask

    logic [31:0] src_data [4];
    int edges;
    int stalls;

    initial begin
        src_data[0] = 32'h1111_1111;
        src_data[1] = 32'h2222_2222;
        src_data[2] = 32'h3333_3333;
        src_data[3] = 32'h4444_4444;
        HRESET = 1'b1;
        start = 1'b0;
        src_addr = 32'h0;
        dst_addr = 32'h0;
        len_words = 16'd0;
        HREADY = 1'b1;
`ifdef AHBL_COPY_IRQ_EN
        irq_clr = 1'b0;
`endif
        tick();
        tick();
        chk("rst_haddr", {36'd0, HADDR}, 68'd0);
        chk("rst_htrans", {66'd0, HTRANS}, 68'd0);
        chk("rst_hsize", {65'd0, HSIZE}, 68'd2);
        chk("rst_hwrite", {67'd0, HWRITE}, 68'd0);
        chk("rst_hwdata", {36'd0, HWDATA}, 68'd0);
        chk("rst_busy", {67'd0, busy}, 68'd0);
        chk("rst_done", {67'd0, done}, 68'd0);
`ifdef AHBL_COPY_IRQ_EN
        chk("rst_irq", {67'd0, irq}, 68'd0);
`endif
        for (int i = 0; i < 4; i++) preload(8'h40 + 8'(i), src_data[i]);
        HRESET = 1'b0;
        tick();

        // Four-word copy at zero wait states.
        log_q.delete();
        run_copy(32'h0000_0100, 32'h0000_0200, 16'd4, 1'b0, edges, stalls);
        chk("lat4_edges", 68'(edges), 68'd9);
        chk("nonseq_count", 68'(log_q.size()), 68'd8);
        for (int i = 0; i < 4; i++) begin
            chk("seq_read", {35'd0, log_q[2*i]}, {36'd0, 32'h100 + 32'(4*i)});
            chk("seq_write", {35'd0, log_q[2*i+1]}, {35'd0, 1'b1, 32'h200 + 32'(4*i)});
            chk("copy_mem", {36'd0, mem[8'h80 + 8'(i)]}, {36'd0, src_data[i]});
        end
        chk("hsize_word", {65'd0, HSIZE}, 68'd2);
        tick();
        chk("done_one_cycle", {67'd0, done}, 68'd0);

        // Same copy with wait states.
        log_q.delete();
        run_copy(32'h0000_0100, 32'h0000_0240, 16'd4, 1'b1, edges, stalls);
        chk("stall_some", 68'(stalls > 0), 68'd1);
        chk("stall_edges", 68'(edges), 68'(9 + stalls));
        chk("stall_nonseq", 68'(log_q.size()), 68'd8);
        for (int i = 0; i < 4; i++)
            chk("stall_mem", {36'd0, mem[8'h90 + 8'(i)]}, {36'd0, src_data[i]});
        tick();

        // Zero-length request.
        src_addr = 32'h0000_0100;
        dst_addr = 32'h0000_0200;
        len_words = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("len0_done", {67'd0, done}, 68'd1);
        chk("len0_busy", {67'd0, busy}, 68'd0);
        chk("len0_htrans", {66'd0, HTRANS}, 68'd0);
        tick();
        chk("len0_done_drop", {67'd0, done}, 68'd0);
        chk("len0_busy2", {67'd0, busy}, 68'd0);
        chk("len0_htrans2", {66'd0, HTRANS}, 68'd0);

        // Source address wraps through 0.
        preload(8'hFE, 32'hAAAA_0001);
        preload(8'hFF, 32'hAAAA_0002);
        preload(8'h00, 32'hAAAA_0003);
        log_q.delete();
        run_copy(32'hFFFF_FFF8, 32'h0000_0300, 16'd3, 1'b0, edges, stalls);
        chk("wrap_edges", 68'(edges), 68'd7);
        chk("wrap_count", 68'(log_q.size()), 68'd6);
        chk("wrap_r0", {35'd0, log_q[0]}, {36'd0, 32'hFFFF_FFF8});
        chk("wrap_w0", {35'd0, log_q[1]}, {35'd0, 1'b1, 32'h0000_0300});
        chk("wrap_r1", {35'd0, log_q[2]}, {36'd0, 32'hFFFF_FFFC});
        chk("wrap_w1", {35'd0, log_q[3]}, {35'd0, 1'b1, 32'h0000_0304});
        chk("wrap_r2", {35'd0, log_q[4]}, {36'd0, 32'h0000_0000});
        chk("wrap_w2", {35'd0, log_q[5]}, {35'd0, 1'b1, 32'h0000_0308});
        chk("wrap_mem0", {36'd0, mem[8'hC0]}, {36'd0, 32'hAAAA_0001});
        chk("wrap_mem1", {36'd0, mem[8'hC1]}, {36'd0, 32'hAAAA_0002});
        chk("wrap_mem2", {36'd0, mem[8'hC2]}, {36'd0, 32'hAAAA_0003});
        tick();

        // Reset during the second write address phase, then a fresh copy.
        src_addr = 32'h0000_0100;
        dst_addr = 32'h0000_02C0;
        len_words = 16'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_hwrite", {67'd0, HWRITE}, 68'd1);
        chk("mid_haddr", {36'd0, HADDR}, {36'd0, 32'h0000_02C4});
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        chk("rst_mid_htrans", {66'd0, HTRANS}, 68'd0);
        chk("rst_mid_busy", {67'd0, busy}, 68'd0);
        chk("rst_mid_done", {67'd0, done}, 68'd0);
        tick();
        chk("rst_mid_no_done", {67'd0, done}, 68'd0);
        chk("rst_mid_idle", {66'd0, HTRANS}, 68'd0);
        log_q.delete();
        run_copy(32'h0000_0100, 32'h0000_02C0, 16'd4, 1'b0, edges, stalls);
        chk("after_rst_edges", 68'(edges), 68'd9);
        for (int i = 0; i < 4; i++)
            chk("after_rst_mem", {36'd0, mem[8'hB0 + 8'(i)]}, {36'd0, src_data[i]});

`ifdef AHBL_COPY_IRQ_EN
        chk("irq_with_done", {67'd0, irq}, 68'd1);
        tick();
        chk("irq_hold", {67'd0, irq}, 68'd1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("irq_cleared", {67'd0, irq}, 68'd0);
        len_words = 16'd0;
        start = 1'b1;
        irq_clr = 1'b1;
        tick();
        start = 1'b0;
        irq_clr = 1'b0;
        chk("irq_set_wins", {67'd0, irq}, 68'd1);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
